// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: write item layout,
// grant source encoding and a helper that decides whether an item really writes.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  killed;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_item_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } gnt_src_e;

    // x0 is hardwired to zero and killed items were superseded by a younger write
    function automatic logic item_writes(input wb_item_t item);
        return (item.rd != 5'd0) && !item.killed;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU results with a parallel WAW kill port that marks every
// entry (including one being pushed this cycle) whose rd matches kill_rd.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  wb_item_t              push_item,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output wb_item_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    wb_item_t        mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;
    logic            push_kill_s;

    assign push_kill_s = kill_en && (push_item.rd == kill_rd);

    // Storage, pointers and occupancy; kill marks are applied before the push write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem_r[i].rd == kill_rd)) begin
                    mem_r[i].killed <= 1'b1;
                end
            end
            if (push) begin
                mem_r[wr_ptr_r]        <= push_item;
                mem_r[wr_ptr_r].killed <= push_item.killed | push_kill_s;
                wr_ptr_r               <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and the
// buffered MDU results, with a starvation guard that stalls the pipeline.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_stall,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  mdu_pending,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_C  = (PW+1)'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [PW:0]   count_s;
    wb_item_t      head_s;
    wb_item_t      push_item_s;
    wb_item_t      win_item_s;
    gnt_src_e      gnt_s;
    logic          pending_s;
    logic          force_s;
    logic          push_s;
    logic          pop_s;
    logic          kill_en_s;
    logic [SW-1:0] starve_cnt_r;

    assign pending_s   = (count_s != '0);
    assign mdu_ready   = (count_s != FULL_C);
    assign mdu_pending = pending_s;
    assign force_s     = pending_s && (starve_cnt_r == LIMIT_C);
    assign pipe_stall  = pipe_valid && force_s;

    assign push_s      = mdu_valid && mdu_ready;
    assign pop_s       = (gnt_s == GNT_MDU);
    assign kill_en_s   = (gnt_s == GNT_PIPE) && (pipe_rd != 5'd0);
    assign push_item_s = '{killed: 1'b0, rd: mdu_rd, data: mdu_data};

    // Pipeline priority unless the FIFO head has been starved long enough
    always_comb begin
        gnt_s = GNT_NONE;
        if (pipe_valid && !force_s) begin
            gnt_s = GNT_PIPE;
        end else if (pending_s) begin
            gnt_s = GNT_MDU;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Select the winning item for the write-port registers
    always_comb begin
        win_item_s = '0;
        case (gnt_s)
            GNT_PIPE: win_item_s = '{killed: 1'b0, rd: pipe_rd, data: pipe_data};
            GNT_MDU:  win_item_s = head_s;
            default:  win_item_s = '0;
        endcase
    end

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_item (push_item_s),
        .pop       (pop_s),
        .kill_en   (kill_en_s),
        .kill_rd   (pipe_rd),
        .head      (head_s),
        .count     (count_s)
    );

    // Count consecutive losses of a non-empty FIFO head, saturating at the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= '0;
        end else if (!pending_s || (gnt_s == GNT_MDU)) begin
            starve_cnt_r <= '0;
        end else if ((gnt_s == GNT_PIPE) && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Registered write port; address/data hold when nothing is granted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (gnt_s != GNT_NONE) begin
            rf_we    <= item_writes(win_item_s);
            rf_rd    <= win_item_s.rd;
            rf_wdata <= win_item_s.data;
        end else begin
            rf_we    <= 1'b0;
            rf_rd    <= rf_rd;
            rf_wdata <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based model predicts register
// writes and handshake outputs; a monitor compares every write the DUT emits.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        pipe_stall;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_rd = 5'd0;
    logic [31:0] mdu_data = 32'd0;
    logic        mdu_pending;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .mdu_pending (mdu_pending),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          killed;
        logic [4:0]  rd;
        logic [31:0] data;
    } mitem_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    mitem_t mq[$];
    exp_t   exp_q[$];
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     starve = 0;
    bit     pipe_stalled = 1'b0;
    bit     mdu_blocked = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every DUT write must match the oldest expected write, in the right cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got x%0d=%0h expected none (cycle %0d)", rf_rd, rf_wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", 32'(rf_rd), 32'(e.rd));
                    check("wr_data", rf_wdata, e.data);
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_write: got none expected x%0d=%0h (cycle %0d)", e.rd, e.data, cyc);
            end
        end
    end

    // Reference model: evaluates each cycle with inputs stable, mid-cycle
    initial begin
        bit     pend, rdy, frc, pipe_win;
        mitem_t h;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_mdu_ready", 32'(mdu_ready), 32'd1);
                check("rst_mdu_pending", 32'(mdu_pending), 32'd0);
                check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
                check("rst_rf_we", 32'(rf_we), 32'd0);
                check("rst_rf_rd", 32'(rf_rd), 32'd0);
                check("rst_rf_wdata", rf_wdata, 32'd0);
                mq.delete();
                starve = 0;
                pipe_stalled = 1'b0;
                mdu_blocked = 1'b0;
            end else begin
                pend = (mq.size() != 0);
                rdy  = (mq.size() < DEPTH);
                frc  = pend && (starve == LIMIT);
                check("mdu_ready", 32'(mdu_ready), 32'(rdy));
                check("mdu_pending", 32'(mdu_pending), 32'(pend));
                check("pipe_stall", 32'(pipe_stall), 32'(pipe_valid && frc));
                pipe_stalled = pipe_valid && frc;
                mdu_blocked  = mdu_valid && !rdy;
                pipe_win     = pipe_valid && !frc;
                if (pipe_win) begin
                    if (pipe_rd != 5'd0) begin
                        exp_q.push_back('{rd: pipe_rd, data: pipe_data, cyc: cyc + 1});
                        foreach (mq[i]) begin
                            if (mq[i].rd == pipe_rd) mq[i].killed = 1'b1;
                        end
                    end
                end else if (pend) begin
                    h = mq.pop_front();
                    if (h.rd != 5'd0 && !h.killed)
                        exp_q.push_back('{rd: h.rd, data: h.data, cyc: cyc + 1});
                end
                if (!pend || !pipe_win) starve = 0;
                else if (starve < LIMIT) starve++;
                if (mdu_valid && rdy)
                    mq.push_back('{killed: pipe_win && (pipe_rd != 5'd0) && (mdu_rd == pipe_rd),
                                   rd: mdu_rd, data: mdu_data});
            end
        end
    end

    // One stimulus cycle; stalled pipe writes and blocked MDU offers are held
    task automatic step(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        @(posedge clock);
        #3;
        if (!pipe_stalled) begin
            pipe_valid = pv;
            pipe_rd    = prd;
            pipe_data  = pd;
        end
        if (!mdu_blocked) begin
            mdu_valid = mv;
            mdu_rd    = mrd;
            mdu_data  = md;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #3;
        reset_n    = 1'b0;
        pipe_valid = 1'b0;
        mdu_valid  = 1'b0;
        repeat (n) @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #30 reset_n = 1'b1;
        idle(2);

        // Pipe-only write
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Starvation: pipe busy, one MDU result
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h12);
        for (int i = 0; i < 8; i++) step(1'b1, 5'(2 + i), 32'h200 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(2);

        // Fill FIFO while pipe busy; third offer must be held
        for (int i = 0; i < 3; i++) step(1'b1, 5'd10, 32'h300 + 32'(i), 1'b1, 5'(20 + i), 32'h400 + 32'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 5'd11, 32'h500 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(4);

        // WAW kill: MDU x9 queued, younger pipe x9 supersedes it
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
        step(1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'd0);
        idle(4);

        // Same-cycle kill of the entry being pushed
        step(1'b1, 5'd12, 32'hBB, 1'b1, 5'd12, 32'hCC);
        idle(4);

        // x0 from both sources
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
        step(1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Reset while FIFO holds two entries
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h55);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        do_reset(2);
        idle(6);

        // Randomized traffic with a narrow register range to provoke kills
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)), $urandom);
            end
        end
        idle(12);

        check("drained_expectations", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
